// File: rtl/sniffer_pkg.sv
// Shared types and defaults for the sniffer sample FIFO.
package sniffer_pkg;

    localparam int unsigned DEPTH_DEFAULT           = 16;
    localparam int unsigned MAX_OUTSTANDING_DEFAULT = 4;

    // One queued write: 32-bit address, 32-bit data, 4-bit byte select (68 bits).
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } fifo_entry_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// Entry storage for sample_wb_fifo: synchronous write, asynchronous read.
module sample_fifo_mem
    import sniffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [AW-1:0] waddr_i,
    input  fifo_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fifo_entry_t rdata_o
);

    fifo_entry_t mem_q [DEPTH];
    fifo_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // No reset: contents are only observed through a valid head pointer.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sample_wb_fifo.sv
// Posted Wishbone write FIFO between the sniffer and the sample RAM.
// Define SAMPLE_FIFO_STATS_EN to build the level high-watermark register.
module sample_wb_fifo
    import sniffer_pkg::*;
#(
    parameter int unsigned DEPTH           = DEPTH_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              s_addr_i,
    input  logic [31:0]              s_data_i,
    input  logic [3:0]               s_sel_i,
    input  logic                     s_we_i,
    input  logic                     s_stb_i,
    output logic                     s_stall_o,
    output logic                     s_ack_o,
    output logic [31:0]              m_addr_o,
    output logic [31:0]              m_data_o,
    output logic [3:0]               m_sel_o,
    output logic                     m_we_o,
    output logic                     m_stb_o,
    input  logic                     m_stall_i,
    input  logic                     m_ack_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     idle_o,
    output logic [$clog2(DEPTH):0]   hwm_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          ack_q, ack_d;

    logic        full;
    logic        accept;
    logic        push;
    logic        issue;
    logic        ack_valid;
    fifo_entry_t wr_entry;
    fifo_entry_t head_entry;

    // Handshake decode. Stall and strobe look only at registered level, so a
    // pop from a full FIFO frees the slot one cycle later.
    always_comb begin
        full      = (level_q == LW'(DEPTH));
        s_stall_o = rst_ni & (full | flush_i);
        accept    = s_stb_i & ~s_stall_o;
        push      = accept & s_we_i;
        m_stb_o   = rst_ni & (level_q != '0) & (outst_q < OW'(MAX_OUTSTANDING)) & ~flush_i;
        issue     = m_stb_o & ~m_stall_i;
        ack_valid = m_ack_i & (outst_q != '0);
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        outst_d = outst_q;
        ack_d   = accept;

        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (issue) begin
                rptr_d = rptr_q + AW'(1);
            end
            unique case ({push, issue})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        unique case ({issue, ack_valid})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            outst_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            outst_q <= outst_d;
            ack_q   <= ack_d;
        end
    end

    assign wr_entry = '{addr: s_addr_i, data: s_data_i, sel: s_sel_i};

    sample_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rptr_q),
        .rdata_o (head_entry)
    );

    // Payload is zeroed whenever no request is presented, including in reset.
    always_comb begin
        m_addr_o = '0;
        m_data_o = '0;
        m_sel_o  = '0;
        m_we_o   = m_stb_o;
        if (m_stb_o) begin
            m_addr_o = head_entry.addr;
            m_data_o = head_entry.data;
            m_sel_o  = head_entry.sel;
        end
    end

    assign s_ack_o = ack_q;
    assign level_o = level_q;
    assign idle_o  = (level_q == '0) && (outst_q == '0);

`ifdef SAMPLE_FIFO_STATS_EN
    logic [LW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (flush_i) begin
            hwm_d = '0;
        end else if (level_q > hwm_q) begin
            hwm_d = level_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`else
    assign hwm_o = '0;
`endif

endmodule

// File: tb/tb_sample_wb_fifo.sv
// Self-checking bench for sample_wb_fifo: vector table plus multi-cycle sequences.
module tb_sample_wb_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] s_addr_i, s_data_i;
    logic [3:0]  s_sel_i;
    logic        s_we_i, s_stb_i;
    logic        s_stall_o, s_ack_o;
    logic [31:0] m_addr_o, m_data_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_stb_o;
    logic        m_stall_i, m_ack_i, flush_i;
    logic [4:0]  level_o, hwm_o;
    logic        idle_o;

    int tests = 0;
    int fails = 0;

    always #8 clk_i = ~clk_i;

    sample_wb_fifo #(
        .DEPTH           (16),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .s_addr_i  (s_addr_i),
        .s_data_i  (s_data_i),
        .s_sel_i   (s_sel_i),
        .s_we_i    (s_we_i),
        .s_stb_i   (s_stb_i),
        .s_stall_o (s_stall_o),
        .s_ack_o   (s_ack_o),
        .m_addr_o  (m_addr_o),
        .m_data_o  (m_data_o),
        .m_sel_o   (m_sel_o),
        .m_we_o    (m_we_o),
        .m_stb_o   (m_stb_o),
        .m_stall_i (m_stall_i),
        .m_ack_i   (m_ack_i),
        .flush_i   (flush_i),
        .level_o   (level_o),
        .idle_o    (idle_o),
        .hwm_o     (hwm_o)
    );

    typedef struct {
        logic        stb;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        mstall;
        logic        mack;
        logic        flush;
        logic        e_stall;
        logic        e_mstb;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_ack;
        logic [4:0]  e_level;
        logic        e_idle;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stb, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] sel,
                         input logic mstall, input logic mack, input logic flush);
        s_stb_i   = stb;
        s_we_i    = we;
        s_addr_i  = addr;
        s_data_i  = data;
        s_sel_i   = sel;
        m_stall_i = mstall;
        m_ack_i   = mack;
        flush_i   = flush;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, 32'(level_o), 32'd0);
        check({tag, "_ack"},   32'(s_ack_o), 32'd0);
        check({tag, "_mstb"},  32'(m_stb_o), 32'd0);
        check({tag, "_stall"}, 32'(s_stall_o), 32'd0);
        check({tag, "_idle"},  32'(idle_o), 32'd1);
        check({tag, "_maddr"}, m_addr_o, 32'd0);
        check({tag, "_mdata"}, m_data_o, 32'd0);
        check({tag, "_msel"},  32'(m_sel_o), 32'd0);
        check({tag, "_mwe"},   32'(m_we_o), 32'd0);
        check({tag, "_hwm"},   32'(hwm_o), 32'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, cnt, issues;
        logic [4:0] exp_hwm;

        // stb we addr data sel mstall mack flush | stall mstb addr data ack level idle
        vecs[0]  = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 32'h20, 32'h11111111, 4'h1, 1'b1, 1'b0, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h24, 32'h22222222, 4'h3, 1'b1, 1'b0, 1'b0,
                     1'b0, 1'b1, 32'h20, 32'h11111111, 1'b1, 5'd2, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h28, 32'h33333333, 4'hC, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 32'h20, 32'h11111111, 1'b1, 5'd2, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b1, 32'h24, 32'h22222222, 1'b0, 5'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 32'h28, 32'h33333333, 1'b0, 5'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1};

        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Vector table: comb outputs checked before the edge, registered ones after.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            drive(vecs[i].stb, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel,
                  vecs[i].mstall, vecs[i].mack, vecs[i].flush);
            #1;
            check($sformatf("v%0d_stall", i), 32'(s_stall_o), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_mstb", i), 32'(m_stb_o), 32'(vecs[i].e_mstb));
            check($sformatf("v%0d_mwe", i), 32'(m_we_o), 32'(vecs[i].e_mstb));
            if (vecs[i].e_mstb) begin
                check($sformatf("v%0d_maddr", i), m_addr_o, vecs[i].e_addr);
                check($sformatf("v%0d_mdata", i), m_data_o, vecs[i].e_data);
            end
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d_ack", i), 32'(s_ack_o), 32'(vecs[i].e_ack));
            check($sformatf("v%0d_level", i), 32'(level_o), 32'(vecs[i].e_level));
            check($sformatf("v%0d_idle", i), 32'(idle_o), 32'(vecs[i].e_idle));
        end

        // 17 writes into a stalled RAM: 16 fit, 17th stalls until a slot frees.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_i);
            drive(1'b1, 1'b1, 32'(32'h100 + 4 * i), 32'(i), 4'hF, 1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("burst_stall%0d", i), 32'(s_stall_o), 32'(i == 16));
            @(posedge clk_i);
        end
        #1;
        check("burst_full_level", 32'(level_o), 32'd16);
        @(negedge clk_i);
        m_stall_i = 1'b0;
        m_ack_i   = 1'b1;
        #1;
        check("full_pop_still_stalled", 32'(s_stall_o), 32'd1);
        check("burst_data0", m_data_o, 32'd0);
        check("burst_addr0", m_addr_o, 32'h100);
        @(posedge clk_i);
        #1;
        check("burst_level_after_pop", 32'(level_o), 32'd15);
        @(negedge clk_i);
        #1;
        check("burst_17th_accept", 32'(s_stall_o), 32'd0);
        check("burst_data1", m_data_o, 32'd1);
        @(posedge clk_i);
        #1;
        check("burst_17th_ack", 32'(s_ack_o), 32'd1);
        check("burst_level_push_pop", 32'(level_o), 32'd15);
        k = 2;
        cnt = 0;
        while (k < 17 && cnt < 40) begin
            @(negedge clk_i);
            s_stb_i = 1'b0;
            #1;
            if (m_stb_o) begin
                check($sformatf("burst_order%0d", k), m_data_o, 32'(k));
                k++;
            end
            @(posedge clk_i);
            cnt++;
        end
        check("burst_issue_count", 32'(k), 32'd17);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        check("burst_drained_idle", 32'(idle_o), 32'd1);

        // Ack starvation: outstanding limit caps issues at four.
        do_reset();
        issues = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            if (c < 10) drive(1'b1, 1'b1, 32'(32'h200 + 4 * c), 32'(32'hA0 + c), 4'hF,
                              1'b0, 1'b0, 1'b0);
            else        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            #1;
            if (m_stb_o && !m_stall_i) issues++;
            @(posedge clk_i);
        end
        #1;
        check("limit_issues", 32'(issues), 32'd4);
        check("limit_mstb_low", 32'(m_stb_o), 32'd0);
        check("limit_level", 32'(level_o), 32'd6);
        @(negedge clk_i);
        m_ack_i = 1'b1;
        @(posedge clk_i);
        issues = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            m_ack_i = 1'b0;
            #1;
            if (m_stb_o && !m_stall_i) begin
                issues++;
                check("limit_next_data", m_data_o, 32'hA4);
            end
            @(posedge clk_i);
        end
        #1;
        check("limit_one_more", 32'(issues), 32'd1);
        check("limit_level_after", 32'(level_o), 32'd5);

        // Flush with 5 queued and 2 outstanding.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            drive(1'b1, 1'b1, 32'(32'h300 + 4 * i), 32'(i), 4'hF, 1'b1, 1'b0, 1'b0);
            @(posedge clk_i);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            @(posedge clk_i);
        end
        #1;
        check("flush_pre_level", 32'(level_o), 32'd5);
`ifdef SAMPLE_FIFO_STATS_EN
        exp_hwm = 5'd7;
`else
        exp_hwm = 5'd0;
`endif
        check("flush_pre_hwm", 32'(hwm_o), 32'(exp_hwm));
        @(negedge clk_i);
        drive(1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check("flush_mstb_suppressed", 32'(m_stb_o), 32'd0);
        check("flush_stall", 32'(s_stall_o), 32'd1);
        @(posedge clk_i);
        #1;
        check("flush_level", 32'(level_o), 32'd0);
        check("flush_idle_busy", 32'(idle_o), 32'd0);
        check("flush_hwm", 32'(hwm_o), 32'd0);
        check("flush_no_ack", 32'(s_ack_o), 32'd0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        #1;
        check("flush_mstb_after", 32'(m_stb_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("flush_idle_one_ack", 32'(idle_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("flush_idle_two_acks", 32'(idle_o), 32'd1);
        @(negedge clk_i);
        m_ack_i = 1'b0;

        // Asynchronous reset in the middle of a stalled burst.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            drive(1'b1, 1'b1, 32'(32'h400 + 4 * i), 32'(32'h55 + i), 4'hF, 1'b1, 1'b0, 1'b0);
            @(posedge clk_i);
        end
        @(negedge clk_i);
        drive(1'b1, 1'b1, 32'h40C, 32'h58, 4'hF, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        drive(1'b1, 1'b1, 32'h410, 32'h59, 4'hF, 1'b1, 1'b0, 1'b0);
        #1;
        check("rst_pre_mstb", 32'(m_stb_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            m_ack_i = 1'b1;
            @(posedge clk_i);
            #1;
            check($sformatf("stray_ack_level%0d", i), 32'(level_o), 32'd0);
            check($sformatf("stray_ack_idle%0d", i), 32'(idle_o), 32'd1);
            check($sformatf("stray_ack_mstb%0d", i), 32'(m_stb_o), 32'd0);
        end
        @(negedge clk_i);
        drive(1'b1, 1'b1, 32'h500, 32'h77, 4'h5, 1'b1, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        check("post_rst_level", 32'(level_o), 32'd1);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        #1;
        check("post_rst_head", m_data_o, 32'h77);
        check("post_rst_sel", 32'(m_sel_o), 32'h5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_wb_fifo.md
SAMPLE_WB_FIFO -- requirements
Module: sample_wb_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, max issued-but-unacked master writes; range 1..15.
REQ-003 SHALL have port clk_i  in  1  the single clock, sniffer 60 MHz domain.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports s_addr_i in 32, s_data_i in 32, s_sel_i in 4, s_we_i in 1, s_stb_i in 1: sniffer-side pipelined Wishbone request.
REQ-006 SHALL have ports s_stall_o out 1, s_ack_o out 1: sniffer-side response.
REQ-007 SHALL have ports m_addr_o out 32, m_data_o out 32, m_sel_o out 4, m_we_o out 1, m_stb_o out 1: sample-RAM-side request.
REQ-008 SHALL have ports m_stall_i in 1, m_ack_i in 1: sample-RAM-side response.
REQ-009 SHALL have port flush_i  in  1  synchronous discard of queued, unissued entries.
REQ-010 SHALL have port level_o  out  $clog2(DEPTH)+1  current entry count.
REQ-011 SHALL have port idle_o  out  1  high when FIFO empty and no outstanding master writes.
REQ-012 SHALL have port hwm_o  out  $clog2(DEPTH)+1  level high-watermark.

Function
REQ-013 Accept SHALL occur when s_stb_i=1 and s_stall_o=0; s_stall_o SHALL equal (level==DEPTH) or flush_i.
REQ-014 An accepted request with s_we_i=1 SHALL be pushed as {addr,data,sel}; with s_we_i=0 it SHALL be dropped, not forwarded.
REQ-015 s_ack_o SHALL pulse exactly one cycle after each accept, posted, independent of master progress.
REQ-016 m_stb_o SHALL be 1 when level>0 and outstanding<MAX_OUTSTANDING; m_addr/data/sel_o SHALL present the head entry; m_we_o SHALL be 1 whenever m_stb_o=1.
REQ-017 Issue SHALL occur when m_stb_o=1 and m_stall_i=0: head popped, outstanding +1.
REQ-018 m_ack_i SHALL decrement outstanding; issue and ack in the same cycle SHALL leave it unchanged; m_ack_i with outstanding==0 SHALL be ignored.
REQ-019 Push and pop in the same cycle SHALL leave level unchanged; a pop when full SHALL NOT unstall the slave side in that cycle.
REQ-020 Head presentation SHALL hold stable while m_stb_o=1 and m_stall_i=1.
REQ-021 Pointers SHALL wrap modulo DEPTH; level SHALL reach exactly DEPTH, never exceed it or go below 0.
REQ-022 flush_i=1 SHALL set level to 0, clear pointers, and suppress m_stb_o that cycle; outstanding and m_ack_i counting SHALL be unaffected.
REQ-023 Queued write order SHALL be preserved end to end.

Reset
REQ-024 While rst_ni=0: level, pointers, outstanding, hwm 0; s_ack_o, m_stb_o, s_stall_o 0; idle_o 1; m_* payload 0.
REQ-025 Reset mid-operation SHALL discard all entries and outstanding count; m_ack_i arriving after reset release for pre-reset writes SHALL be ignored via REQ-018.

Configuration
REQ-026 With SAMPLE_FIFO_STATS_EN defined, hwm_o SHALL track max level since reset or last flush_i, updating one cycle after level.
REQ-027 Without SAMPLE_FIFO_STATS_EN, hwm_o SHALL be constant 0 and no watermark register SHALL be built.

Structure
REQ-028 Package sniffer_pkg SHALL hold the FIFO entry typedef (addr 32, data 32, sel 4 = 68 bits) and the DEPTH/MAX_OUTSTANDING defaults.
REQ-029 Storage SHALL be sub-module sample_fifo_mem, a synchronous-write, asynchronous-read register array; pointer, level, and outstanding control stays in sample_wb_fifo.

Verification
REQ-030 Single write addr 0x10, data 0xDEADBEEF, sel 0xF, RAM no stall -> s_ack_o at T+1; m_stb_o with same payload at T+1; idle_o returns 1 after m_ack_i.
REQ-031 17 back-to-back writes, m_stall_i=1 -> 16 accepted, s_stall_o=1 on 17th, level_o=16; release stall -> 16 issues in order, 17th accepted next cycle.
REQ-032 m_ack_i held 0, 10 queued writes -> exactly 4 issues, m_stb_o=0 with level_o=6; one m_ack_i -> one further issue.
REQ-033 flush_i with 5 queued, 2 outstanding -> level_o=0 next cycle, idle_o=0 until 2 acks, then 1; hwm_o 0 with SAMPLE_FIFO_STATS_EN.
REQ-034 Read request (s_we_i=0) -> s_ack_o pulses, level_o unchanged, no m_stb_o.
REQ-035 rst_ni low during stalled burst -> all outputs at REQ-024 values immediately; stray m_ack_i after release -> no state change.
